// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: scrub FSM states and
// default geometry.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_SCRUB,
    RF_DONE
  } rf_state_e;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

endpackage

// File: rtl/rf_scrub_ctrl.sv
// Scrub sequencer: walks the array one entry per cycle, emitting a zeroing
// write, then pulses scrub_done for a single cycle.
module rf_scrub_ctrl
  import rf_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_scrub_start,
  output logic          o_scrub_we,
  output logic [AW-1:0] o_scrub_addr,
  output logic          o_busy,
  output logic          o_scrub_done
);

  // Entry 0 is never written when it is hardwired, so the walk can skip it.
  localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  rf_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of process ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= RF_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_scrub_we   = 1'b0;
    o_busy       = 1'b0;
    o_scrub_done = 1'b0;
    case (r_state)
      RF_IDLE: begin
        if (i_scrub_start) begin
          w_state_nxt = RF_SCRUB;
          w_cnt_nxt   = FIRST_IDX;
        end
      end
      RF_SCRUB: begin
        o_scrub_we = 1'b1;
        o_busy     = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = RF_DONE;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      RF_DONE: begin
        o_scrub_done = 1'b1;
        w_state_nxt  = RF_IDLE;
      end
      default: w_state_nxt = RF_IDLE;
    endcase
  end

  assign o_scrub_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero entry,
// optional write bypass, optional registered reads and a scrub engine.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                wr_ready,
  input  logic                scrub_start,
  output logic                busy,
  output logic                scrub_done
);

  logic [XLEN-1:0] r_mem [NREG];

  logic          w_scrub_we;
  logic [AW-1:0] w_scrub_addr;
  logic          w_wr_commit;

  rf_scrub_ctrl #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_scrub (
    .clk           (clk),
    .clr           (clr),
    .i_scrub_start (scrub_start),
    .o_scrub_we    (w_scrub_we),
    .o_scrub_addr  (w_scrub_addr),
    .o_busy        (busy),
    .o_scrub_done  (scrub_done)
  );

  assign wr_ready    = ~busy;
  assign w_wr_commit = we && wr_ready && !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: the array is reset explicitly because reset must read as all-zero
  // immediately; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      // Writes and scrub writes are exclusive: writes need !busy.
      if (w_wr_commit) r_mem[wr_addr] <= wr_data;
      if (w_scrub_we)  r_mem[w_scrub_addr] <= '0;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_zero;
    logic          w_hit;

    assign w_addr = rd_addr[gi*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
    assign w_hit  = w_wr_commit && (wr_addr == w_addr);

    if (REG_READ != 0) begin : g_reg
      logic [XLEN-1:0] r_rd;
      // Capture the post-edge contents, so a same-edge write is always seen.
      always_ff @(posedge clk or posedge clr) begin
        if (clr)                                          r_rd <= '0;
        else if (w_zero)                                  r_rd <= '0;
        else if (w_hit)                                   r_rd <= wr_data;
        else if (w_scrub_we && (w_scrub_addr == w_addr)) r_rd <= '0;
        else                                              r_rd <= r_mem[w_addr];
      end
      assign rd_data[gi*XLEN +: XLEN] = r_rd;
    end else begin : g_comb
      assign rd_data[gi*XLEN +: XLEN] = w_zero                     ? '0      :
                                        ((BYPASS != 0) && w_hit)   ? wr_data :
                                                                     r_mem[w_addr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: three instances (bypass, no bypass,
// registered 4-port read) share stimulus and are compared to an array model.
module tb_regfile_mp;

  logic         clk;
  logic         clr;
  logic         we;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         scrub_start;
  logic [9:0]   rd_addr2;
  logic [19:0]  rd_addr4;

  logic [63:0]  rd_a, rd_b;
  logic [127:0] rd_c;
  logic         ready_a, busy_a, done_a;
  logic         ready_b, busy_b, done_b;
  logic         ready_c, busy_c, done_c;

  int n_pass;
  int n_total;

  // Reference model: array contents plus scrub progress (next index to clear).
  logic [31:0] m [32];
  int          scrub_idx;
  bit          m_done;
  logic [31:0] rr_exp [4];

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1), .REG_READ(0)) u_dut (
    .clk(clk), .clr(clr), .rd_addr(rd_addr2), .rd_data(rd_a), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(ready_a), .scrub_start(scrub_start), .busy(busy_a),
    .scrub_done(done_a));

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0), .REG_READ(0)) u_nb (
    .clk(clk), .clr(clr), .rd_addr(rd_addr2), .rd_data(rd_b), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(ready_b), .scrub_start(scrub_start), .busy(busy_b),
    .scrub_done(done_b));

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(4), .ZERO_REG(1), .BYPASS(1), .REG_READ(1)) u_rr (
    .clk(clk), .clr(clr), .rd_addr(rd_addr4), .rd_data(rd_c), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(ready_c), .scrub_start(scrub_start), .busy(busy_c),
    .scrub_done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    for (int i = 0; i < 4; i++) rr_exp[i] = '0;
    scrub_idx = -1;
    m_done    = 1'b0;
  endtask

  // Expected combinational read value for the current inputs.
  function automatic logic [31:0] exp_comb(logic [4:0] a, bit byp);
    if (a == 5'd0) return '0;
    if (byp && we && (scrub_idx < 0) && (wr_addr == a)) return wr_data;
    return m[a];
  endfunction

  // One rising edge; model follows the behavioural rules, ends at edge + 1.
  task automatic tick();
    logic        c_we  = we;
    logic [4:0]  c_wa  = wr_addr;
    logic [31:0] c_wd  = wr_data;
    logic        c_ss  = scrub_start;
    logic [19:0] c_ra4 = rd_addr4;
    bit          new_done = 1'b0;
    @(posedge clk);
    if (c_we && (scrub_idx < 0) && (c_wa != 5'd0)) m[c_wa] = c_wd;
    if (scrub_idx >= 0) begin
      m[scrub_idx] = '0;
      scrub_idx++;
      if (scrub_idx == 32) begin
        scrub_idx = -1;
        new_done  = 1'b1;
      end
    end else if (!m_done && c_ss) begin
      scrub_idx = 1;
    end
    m_done = new_done;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a = c_ra4[i*5 +: 5];
      rr_exp[i] = (a == 5'd0) ? '0 : m[a];
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    clr = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      we = 1'b1; wr_addr = 5'(a); wr_data = $urandom | 32'h1;
      tick();
    end
    we = 1'b0;
    #3;
    clr = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_c !== 1'b0 || done_c !== 1'b0)
      $display("FAIL reset_status: busy=%b/%b done=%b/%b, want all 0", busy_a, busy_c, done_a, done_c);
    else n_pass++;
    n_total++;
    if (rd_c !== 128'd0) $display("FAIL reset_regread: got %h want 0", rd_c);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      rd_addr2 = {5'(31 - a), 5'(a)};
      #1;
      n_total++;
      if (rd_a !== 64'd0) $display("FAIL reset_read addr=%0d: got %h want 0", a, rd_a);
      else n_pass++;
    end
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_basic();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    we = 1'b0; rd_addr2 = {5'd0, 5'd5};
    #1;
    n_total++;
    if (rd_a !== {32'd0, 32'hDEADBEEF}) $display("FAIL basic_read: got %h want 00000000deadbeef", rd_a);
    else n_pass++;
    n_total++;
    if (rd_b !== {32'd0, 32'hDEADBEEF}) $display("FAIL basic_read_nb: got %h want 00000000deadbeef", rd_b);
    else n_pass++;
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr2 = {5'd0, 5'd0}; rd_addr4 = '0;
    #1;
    n_total++;
    if (rd_a !== 64'd0) $display("FAIL zero_bypass: got %h want 0", rd_a);
    else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rd_a !== 64'd0 || rd_b !== 64'd0) $display("FAIL zero_write: got %h / %h want 0", rd_a, rd_b);
    else n_pass++;
    n_total++;
    if (rd_c !== 128'd0) $display("FAIL zero_write_rr: got %h want 0", rd_c);
    else n_pass++;
  endtask

  task automatic test_bypass();
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    tick();
    wr_data = 32'hA5A5A5A5; rd_addr2 = {5'd7, 5'd7};
    #1;
    n_total++;
    if (rd_a[31:0] !== 32'hA5A5A5A5) $display("FAIL bypass_on: got %h want a5a5a5a5", rd_a[31:0]);
    else n_pass++;
    n_total++;
    if (rd_b[31:0] !== 32'h77) $display("FAIL bypass_off: got %h want 00000077", rd_b[31:0]);
    else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rd_b !== {2{32'hA5A5A5A5}}) $display("FAIL bypass_commit: got %h want a5a5a5a5a5a5a5a5", rd_b);
    else n_pass++;
  endtask

  task automatic test_regread();
    rd_addr4 = {4{5'd3}};
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    tick();
    n_total++;
    if (rd_c !== {4{32'h55}}) $display("FAIL regread_same_edge: got %h want 4x00000055", rd_c);
    else n_pass++;
    wr_data = 32'h66;
    #1;
    n_total++;
    if (rd_c !== {4{32'h55}}) $display("FAIL regread_hold: got %h want 4x00000055", rd_c);
    else n_pass++;
    tick();
    we = 1'b0;
    n_total++;
    if (rd_c !== {4{32'h66}}) $display("FAIL regread_update: got %h want 4x00000066", rd_c);
    else n_pass++;
  endtask

  task automatic test_random(int n);
    for (int k = 0; k < n; k++) begin
      we          = 1'($urandom_range(0, 1));
      wr_addr     = 5'($urandom);
      wr_data     = $urandom;
      rd_addr2    = 10'($urandom);
      rd_addr4    = 20'($urandom);
      scrub_start = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) rd_addr2[4:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr4[9:5] = wr_addr;
      #1;
      n_total++;
      if (busy_a !== (scrub_idx >= 0) || ready_a !== (scrub_idx < 0) || done_a !== m_done ||
          busy_c !== (scrub_idx >= 0) || done_c !== m_done)
        $display("FAIL rand_status k=%0d: busy=%b ready=%b done=%b want busy=%b done=%b",
                 k, busy_a, ready_a, done_a, scrub_idx >= 0, m_done);
      else n_pass++;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a = rd_addr2[p*5 +: 5];
        n_total++;
        if (rd_a[p*32 +: 32] !== exp_comb(a, 1'b1) || rd_b[p*32 +: 32] !== exp_comb(a, 1'b0))
          $display("FAIL rand_read k=%0d port=%0d addr=%0d: got %h/%h want %h/%h", k, p, a,
                   rd_a[p*32 +: 32], rd_b[p*32 +: 32], exp_comb(a, 1'b1), exp_comb(a, 1'b0));
        else n_pass++;
      end
      for (int p = 0; p < 4; p++) begin
        n_total++;
        if (rd_c[p*32 +: 32] !== rr_exp[p])
          $display("FAIL rand_regread k=%0d port=%0d: got %h want %h", k, p, rd_c[p*32 +: 32], rr_exp[p]);
        else n_pass++;
      end
      tick();
    end
    we = 1'b0;
    scrub_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    we = 1'b0; scrub_start = 1'b0;
    while ((scrub_idx >= 0 || m_done) && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic test_scrub();
    wait_idle();
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
      tick();
    end
    we = 1'b0;
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      bit          e_busy = (c <= 31);
      bit          e_done = (c == 32);
      logic [31:0] e_p0   = (c <= 31) ? 32'(c) : 32'd0;
      if (c == 10) begin we = 1'b1; wr_addr = 5'd9; wr_data = 32'hBAD; end
      if (c == 20) scrub_start = 1'b1;
      rd_addr2 = {5'(c - 1), 5'(c)};
      #1;
      n_total++;
      if (busy_a !== e_busy || ready_a !== !e_busy || done_a !== e_done)
        $display("FAIL scrub_timing c=%0d: busy=%b ready=%b done=%b want busy=%b done=%b",
                 c, busy_a, ready_a, done_a, e_busy, e_done);
      else n_pass++;
      n_total++;
      if (rd_a !== {32'd0, e_p0}) $display("FAIL scrub_read c=%0d: got %h want %h", c, rd_a, {32'd0, e_p0});
      else n_pass++;
      tick();
      we = 1'b0; scrub_start = 1'b0;
    end
    #1;
    n_total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL scrub_restart: busy=%b done=%b want 0 0", busy_a, done_a);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      rd_addr2 = {5'(a), 5'(a)};
      #1;
      n_total++;
      if (rd_a !== 64'd0) $display("FAIL scrub_clear addr=%0d: got %h want 0", a, rd_a);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scrub();
    int c;
    wait_idle();
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wr_addr = 5'(a); wr_data = 32'h100 + 32'(a);
      tick();
    end
    we = 1'b0;
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    for (c = 1; c < 12; c++) begin
      n_total++;
      if (done_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL abort_pre c=%0d: busy=%b done=%b want 1 0", c, busy_a, done_a);
      else n_pass++;
      tick();
    end
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || ready_a !== 1'b1)
      $display("FAIL abort_status: busy=%b done=%b ready=%b want 0 0 1", busy_a, done_a, ready_a);
    else n_pass++;
    for (int a = 0; a < 32; a++) begin
      rd_addr2 = {5'(31 - a), 5'(a)};
      #1;
      n_total++;
      if (rd_a !== 64'd0) $display("FAIL abort_clear addr=%0d: got %h want 0", a, rd_a);
      else n_pass++;
    end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL abort_quiet k=%0d: busy=%b done=%b want 0 0", k, busy_a, done_a);
      else n_pass++;
    end
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    c = 1;
    while (done_a !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    n_total++;
    if (c != 32) $display("FAIL rescrub_latency: done at cycle %0d want 32", c);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    clr = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; scrub_start = 1'b0;
    rd_addr2 = '0; rd_addr4 = '0;
    model_reset();
    test_reset();
    test_basic();
    test_bypass();
    test_regread();
    test_random(400);
    test_scrub();
    test_reset_mid_scrub();
    wait_idle();
    test_random(200);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
